// File: rtl/lfsr_bist_engine_if.sv
// Control and data bundle for the LFSR BIST engine: mode/start/load/data
// inputs towards the engine, and the register contents and status back out.
interface lfsr_bist_engine_if #(
    parameter int NBIT = 8
);
    logic [1:0]      mode;
    logic            start;
    logic            load;
    logic [NBIT-1:0] data_in;
    logic            scan_in;
    logic [NBIT-1:0] out;
    logic            scan_out;
    logic            busy;
    logic            done;

    modport master (
        output mode, start, load, data_in, scan_in,
        input  out, scan_out, busy, done
    );

    modport slave (
        input  mode, start, load, data_in, scan_in,
        output out, scan_out, busy, done
    );
endinterface

// File: rtl/lfsr_bist_engine.sv
// Fibonacci LFSR usable as pattern generator (PRPG), signature register (MISR)
// or plain scan chain, sequenced by an IDLE/RUN/DONE controller.
module lfsr_bist_engine #(
    parameter int              NBIT = 8,
    parameter logic [NBIT-1:0] TAPS = NBIT'('hB8),
    parameter logic [NBIT-1:0] SEED = '1,
    parameter int              NPAT = 255
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_bist_engine_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] M_PRPG = 2'b01;
    localparam logic [1:0] M_MISR = 2'b10;
    localparam logic [1:0] M_SCAN = 2'b11;

    localparam int            CW   = $clog2(NPAT + 1);
    localparam logic [CW-1:0] LAST = CW'(NPAT - 1);

    state_t          state_q, state_d;
    logic [NBIT-1:0] dff_q, dff_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            misr_q, misr_d;
    logic            run_req;

    function automatic logic [NBIT-1:0] shift_fb(input logic [NBIT-1:0] r);
        return {r[NBIT-2:0], ^(r & TAPS)};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dff_q   <= SEED;
            cnt_q   <= '0;
            misr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dff_q   <= dff_d;
            cnt_q   <= cnt_d;
            misr_q  <= misr_d;
        end
    end

    // A run may only be launched in a stepping mode; hold and scan ignore start.
    assign run_req = bus.start && (bus.mode == M_PRPG || bus.mode == M_MISR);

    always_comb begin
        state_d = state_q;
        dff_d   = dff_q;
        cnt_d   = cnt_q;
        misr_d  = misr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    dff_d = bus.data_in;
                end else if (bus.mode == M_SCAN) begin
                    dff_d = {dff_q[NBIT-2:0], bus.scan_in};
                end else if (run_req) begin
                    misr_d  = (bus.mode == M_MISR);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                dff_d = misr_q ? (shift_fb(dff_q) ^ bus.data_in) : shift_fb(dff_q);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.load) begin
                    dff_d   = bus.data_in;
                    state_d = S_IDLE;
                end else if (run_req) begin
                    misr_d  = (bus.mode == M_MISR);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (bus.mode == M_SCAN) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.out      = dff_q;
        bus.scan_out = dff_q[NBIT-1];
        bus.busy     = (state_q == S_RUN);
        bus.done     = (state_q == S_DONE);
    end
endmodule

// File: tb/tb_lfsr_bist_engine.sv
// Directed bench for lfsr_bist_engine with NBIT=4, TAPS=1100, SEED=1111:
// a vector table for PRPG/scan/priority/reset, plus hand sequences.
module tb_lfsr_bist_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_bist_engine_if #(.NBIT(4)) bus_a ();
    lfsr_bist_engine_if #(.NBIT(4)) bus_b ();

    lfsr_bist_engine #(.NBIT(4), .TAPS(4'b1100), .SEED(4'b1111), .NPAT(15)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    lfsr_bist_engine #(.NBIT(4), .TAPS(4'b1100), .SEED(4'b1111), .NPAT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic       start;
        logic       load;
        logic [3:0] data_in;
        logic       scan_in;
        logic [3:0] exp_out;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0] prpg_seq [15] = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010,
                                  4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101,
                                  4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111};

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] m, input logic s, input logic l,
                       input logic [3:0] d, input logic si,
                       input logic [3:0] eo, input logic eb, input logic ed);
        vec_t v;
        v = '{rst: r, mode: m, start: s, load: l, data_in: d, scan_in: si,
              exp_out: eo, exp_busy: eb, exp_done: ed};
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] m, input logic s, input logic l,
                           input logic [3:0] d, input logic si);
        bus_a.mode = m; bus_a.start = s; bus_a.load = l; bus_a.data_in = d; bus_a.scan_in = si;
    endtask

    // Launch a run on dut_a and count busy cycles until done, bounded.
    task automatic run_a(input logic [1:0] m, output int busy_cnt);
        drive_a(m, 1'b1, 1'b0, 4'b0000, 1'b0);
        tick();
        drive_a(2'b00, 1'b0, 1'b0, 4'b0000, 1'b0);
        busy_cnt = 0;
        for (int c = 0; c < 40 && !bus_a.done; c++) begin
            if (bus_a.busy) busy_cnt++;
            tick();
        end
        chk("run_done", {3'b000, bus_a.done}, 4'b0001);
    endtask

    initial begin
        int bc;
        drive_a(2'b00, 1'b0, 1'b0, 4'b0000, 1'b0);
        bus_b.mode = 2'b00; bus_b.start = 1'b0; bus_b.load = 1'b0;
        bus_b.data_in = 4'b0000; bus_b.scan_in = 1'b0;

        // rst mode st ld din si | out busy done
        add(1, 2'b00, 0, 0, 4'b0000, 0, 4'b1111, 0, 0);
        add(0, 2'b11, 0, 0, 4'b0000, 1, 4'b1111, 0, 0);
        add(0, 2'b11, 0, 0, 4'b0000, 0, 4'b1110, 0, 0);
        add(0, 2'b11, 0, 0, 4'b0000, 1, 4'b1101, 0, 0);
        add(0, 2'b11, 0, 0, 4'b0000, 0, 4'b1010, 0, 0);
        add(0, 2'b01, 1, 1, 4'b0101, 0, 4'b0101, 0, 0);
        add(0, 2'b00, 0, 0, 4'b1001, 0, 4'b0101, 0, 0);
        add(0, 2'b11, 1, 0, 4'b0000, 1, 4'b1011, 0, 0);
        add(0, 2'b00, 0, 1, 4'b1111, 0, 4'b1111, 0, 0);
        add(0, 2'b01, 1, 0, 4'b0000, 0, 4'b1111, 1, 0);
        for (int k = 0; k < 15; k++)
            add(0, 2'(k), k[0], ~k[0], 4'(k * 3), k[1], prpg_seq[k], (k < 14), (k == 14));
        add(0, 2'b00, 0, 0, 4'b0000, 0, 4'b1111, 0, 1);
        add(0, 2'b01, 1, 0, 4'b0000, 0, 4'b1111, 1, 0);
        add(0, 2'b00, 0, 0, 4'b0000, 0, 4'b1110, 1, 0);
        add(0, 2'b00, 0, 0, 4'b0000, 0, 4'b1100, 1, 0);
        add(0, 2'b00, 0, 0, 4'b0000, 0, 4'b1000, 1, 0);
        add(0, 2'b00, 0, 0, 4'b0000, 0, 4'b0001, 1, 0);
        add(1, 2'b01, 1, 1, 4'b0110, 1, 4'b1111, 0, 0);
        add(0, 2'b00, 0, 0, 4'b0000, 0, 4'b1111, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            drive_a(vecs[i].mode, vecs[i].start, vecs[i].load, vecs[i].data_in, vecs[i].scan_in);
            tick();
            chk($sformatf("v%0d_out", i), bus_a.out, vecs[i].exp_out);
            chk($sformatf("v%0d_busy", i), {3'b000, bus_a.busy}, {3'b000, vecs[i].exp_busy});
            chk($sformatf("v%0d_done", i), {3'b000, bus_a.done}, {3'b000, vecs[i].exp_done});
            chk($sformatf("v%0d_sout", i), {3'b000, bus_a.scan_out}, {3'b000, vecs[i].exp_out[3]});
        end
        rst = 1'b0;

        // Full run after an abandoned one: exactly NPAT busy cycles.
        run_a(2'b01, bc);
        chk("full_busy_cnt", 4'(bc), 4'd15);
        chk("full_out", bus_a.out, 4'b1111);

        // Load from DONE returns to IDLE.
        drive_a(2'b00, 1'b0, 1'b1, 4'b0011, 1'b0);
        tick();
        chk("done_load_out", bus_a.out, 4'b0011);
        chk("done_load_st", {2'b00, bus_a.busy, bus_a.done}, 4'b0000);

        // Maximal-length sequence returns to its start after 15 steps.
        run_a(2'b01, bc);
        chk("run2_out", bus_a.out, 4'b0011);

        // Scan mode in DONE leaves to IDLE without stepping, then scans.
        drive_a(2'b11, 1'b0, 1'b0, 4'b0000, 1'b1);
        tick();
        chk("done_scan_out", bus_a.out, 4'b0011);
        chk("done_scan_st", {2'b00, bus_a.busy, bus_a.done}, 4'b0000);
        tick();
        chk("idle_scan_out", bus_a.out, 4'b0111);

        // MISR with NPAT=1.
        bus_b.mode = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("b_reset_out", bus_b.out, 4'b1111);
        bus_b.mode = 2'b10; bus_b.start = 1'b1; bus_b.data_in = 4'b0001;
        tick();
        bus_b.mode = 2'b00; bus_b.start = 1'b0;
        chk("b_busy", {3'b000, bus_b.busy}, 4'b0001);
        tick();
        chk("b_sig1", bus_b.out, 4'b1111);
        chk("b_done1", {2'b00, bus_b.busy, bus_b.done}, 4'b0001);
        bus_b.mode = 2'b10; bus_b.start = 1'b1; bus_b.data_in = 4'b0110;
        tick();
        bus_b.mode = 2'b00; bus_b.start = 1'b0;
        tick();
        chk("b_sig2", bus_b.out, 4'b1000);
        chk("b_done2", {2'b00, bus_b.busy, bus_b.done}, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_bist_engine.md
LFSR_BIST_ENGINE -- requirements
Module: lfsr_bist_engine

Interface
REQ-001 The block SHALL have parameter NBIT, default 8: register width, legal range 2..32.
REQ-002 The block SHALL have parameter TAPS, default 8'hB8: feedback mask; bit i set means dff[i] feeds the XOR.
REQ-003 The block SHALL have parameter SEED, default all-ones: reset value; SEED == 0 is unsupported.
REQ-004 The block SHALL have parameter NPAT, default 255: steps per run, legal range 1..2^NBIT-1.
REQ-005 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 hold, 01 PRPG, 10 MISR, 11 scan.
REQ-008 The block SHALL have port start, input, 1 bit: begins a run of the selected mode.
REQ-009 The block SHALL have port load, input, 1 bit: loads data_in into the register.
REQ-010 The block SHALL have port data_in, input, NBIT bits: load value, or MISR signature input.
REQ-011 The block SHALL have port scan_in, input, 1 bit: serial input in scan mode.
REQ-012 The block SHALL have port out, output, NBIT bits: the register contents dff.
REQ-013 The block SHALL have port scan_out, output, 1 bit: dff[NBIT-1].
REQ-014 The block SHALL have port busy, output, 1 bit: high in state RUN.
REQ-015 The block SHALL have port done, output, 1 bit: high in state DONE.

Function
REQ-016 The block SHALL use the feedback bit fb = XOR-reduce(dff AND TAPS).
REQ-017 A PRPG step SHALL be dff <= {dff[NBIT-2:0], fb}.
REQ-018 A MISR step SHALL be dff <= {dff[NBIT-2:0], fb} XOR data_in.
REQ-019 A scan step SHALL be dff <= {dff[NBIT-2:0], scan_in}, with no feedback.
REQ-020 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-021 In IDLE with load=1, the block SHALL load dff <= data_in; load SHALL take priority over start and scan.
REQ-022 In IDLE with mode=11 and load=0, the block SHALL perform one scan step per cycle, and start SHALL be ignored.
REQ-023 In IDLE with mode=00 or 11, start SHALL have no effect.
REQ-024 In IDLE with start=1, mode in {01,10} and load=0, the block SHALL latch mode, clear the counter and go to RUN; dff SHALL be unchanged in that cycle.
REQ-025 In RUN, the block SHALL perform one step per cycle in the latched mode, and the counter SHALL increment.
REQ-026 In RUN, changes on mode, start, load and scan_in SHALL be ignored.
REQ-027 RUN SHALL perform exactly NPAT steps; the step at which the counter equals NPAT-1 SHALL move the FSM to DONE.
REQ-028 The counter width SHALL be ceil(log2(NPAT+1)), and the counter SHALL never wrap.
REQ-029 In DONE, dff SHALL hold (signature or last pattern) and done SHALL be 1.
REQ-030 In DONE, start=1 SHALL behave as in IDLE and begin a new run from the current dff; load=1 SHALL load and go to IDLE.
REQ-031 In DONE with mode=11 and start=0, the block SHALL go to IDLE without stepping.
REQ-032 In IDLE with mode=00 and no load, dff SHALL hold.
REQ-033 scan_out SHALL always equal dff[NBIT-1] combinationally from the register; there SHALL be no extra latency.

Reset
REQ-034 With rst=1 at a clock edge, the block SHALL set dff=SEED, state=IDLE and counter=0, so that busy=0 and done=0 on the next cycle.
REQ-035 rst SHALL override all other inputs, including during RUN; a partial run SHALL be abandoned with no done pulse.

Verification
REQ-036 PRPG (NBIT=4, TAPS=4'b1100, SEED=4'b1111, NPAT=15): start with mode=01 -> out steps 1110, 1100, 1000, 0001, 0010, 0100, 1001, 0011, ... back to 1111 after 15 steps; busy high for 15 cycles; then done=1.
REQ-037 MISR (same parameters, NPAT=1): from 1111 with data_in=0001 -> out=1111 and done=1 after one step.
REQ-038 Scan: from 1111 in IDLE with mode=11, scan_in=1,0,1,0 -> out=1111, 1110, 1101, 1010; scan_out=1 each cycle.
REQ-039 Reset in RUN: assert rst on the 5th RUN cycle -> next cycle out=1111, busy=0, done=0; a later start runs the full NPAT steps.
REQ-040 Priority: in IDLE drive load=1, start=1, data_in=0101 -> out=0101, state stays IDLE, busy=0.
REQ-041 Restart: in DONE drive start=1 with mode=01 -> busy=1 next cycle; the run continues from the held dff.
